// File: rtl/sample_stream_pkg.sv
// Shared types and constants for the tagged sample-stream mux.
// Frame header is {seq, ch}; payload is sent least significant byte first.
package sample_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        TIMESTAMP,
        PAYLOAD
    } state_t;

    localparam int HEADER_CH_WIDTH = 4;
    localparam int SEQ_WIDTH       = 4;
    localparam int TIMESTAMP_WIDTH = 16;

    function automatic int bytes_per_sample(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req upward from ptr, wrapping, and grants the first hit.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]                      req,
    input  logic [$clog2((N > 1) ? N : 2)-1:0] ptr,
    input  logic                              enable,
    output logic [N-1:0]                      grant,
    output logic [$clog2((N > 1) ? N : 2)-1:0] grant_idx,
    output logic                              any_grant
);
    import sample_stream_pkg::*;

    localparam int PW = $clog2((N > 1) ? N : 2);

    logic [PW-1:0] idx;

    // first requester at or after ptr, modulo N
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (enable && !any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_stream_mux.sv
// N-channel AXIS sample mux producing tagged byte frames.
// Optional SAMPLE_STREAM_MUX_TIMESTAMP_EN inserts a 16-bit timestamp.
module sample_stream_mux #(
    parameter int NUM_CHANNELS = 4,
    parameter int SAMPLE_WIDTH = 32,
    parameter int SEQ_WIDTH    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] s_tdata,
    input  logic [NUM_CHANNELS-1:0]              s_tvalid,
    output logic [NUM_CHANNELS-1:0]              s_tready,
    output logic [7:0]                           m_tdata,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic                                 m_tlast,
    output logic [31:0]                          frames_sent
);
    import sample_stream_pkg::*;

    localparam int NB = bytes_per_sample(SAMPLE_WIDTH);
    localparam int PW = $clog2((NUM_CHANNELS > 1) ? NUM_CHANNELS : 2);
    localparam int BW = $clog2((NB > 1) ? NB : 2);

    state_t                  state;
    logic [SAMPLE_WIDTH-1:0] sample_q;
    logic [SAMPLE_WIDTH-1:0] sel_sample;
    logic [7:0]              sample_bytes [NB];
    logic [PW-1:0]           ch_q;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           grant_idx;
    logic [SEQ_WIDTH-1:0]    seq_q [NUM_CHANNELS];
    logic [BW-1:0]           byte_idx;
    logic [BW-1:0]           nxt_idx;
    logic [NUM_CHANNELS-1:0] grant;
    logic                    any_grant;
    logic                    arb_en;
    logic                    last_byte;
    logic [7:0]              hdr_byte;

`ifdef SAMPLE_STREAM_MUX_TIMESTAMP_EN
    logic [TIMESTAMP_WIDTH-1:0] cyc_cnt;
    logic [TIMESTAMP_WIDTH-1:0] ts_q;
    logic                       ts_hi;
`endif

    // inputs are only offered a grant between frames
    assign arb_en = (state == IDLE) && !rst;

    rr_arbiter #(
        .N(NUM_CHANNELS)
    ) u_arb (
        .req      (s_tvalid),
        .ptr      (ptr),
        .enable   (arb_en),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any_grant(any_grant)
    );

    assign s_tready  = grant;
    assign nxt_idx   = byte_idx + BW'(1);
    assign last_byte = (byte_idx == BW'(NB - 1));
    assign hdr_byte  = {seq_q[grant_idx],
                        HEADER_CH_WIDTH'(grant_idx)};

    // pick the granted channel's sample word
    always_comb begin
        sel_sample = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (grant[k]) begin
                sel_sample = s_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
    end

    // split the latched sample into payload bytes, LSB first
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            sample_bytes[b] = sample_q[8*b +: 8];
        end
    end

`ifdef SAMPLE_STREAM_MUX_TIMESTAMP_EN
    // free-running cycle counter stamped into each frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + TIMESTAMP_WIDTH'(1);
        end
    end
`endif

    // frame FSM with registered AXIS output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sample_q    <= '0;
            ch_q        <= '0;
            ptr         <= '0;
            byte_idx    <= '0;
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            frames_sent <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                seq_q[k] <= '0;
            end
`ifdef SAMPLE_STREAM_MUX_TIMESTAMP_EN
            ts_q        <= '0;
            ts_hi       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_grant) begin
                        sample_q <= sel_sample;
                        ch_q     <= grant_idx;
                        m_tdata  <= hdr_byte;
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b0;
                        byte_idx <= '0;
`ifdef SAMPLE_STREAM_MUX_TIMESTAMP_EN
                        ts_q     <= cyc_cnt;
                        ts_hi    <= 1'b0;
`endif
                        state    <= HEADER;
                    end
                end
                HEADER: begin
                    if (m_tready) begin
`ifdef SAMPLE_STREAM_MUX_TIMESTAMP_EN
                        m_tdata <= ts_q[7:0];
                        state   <= TIMESTAMP;
`else
                        m_tdata <= sample_bytes[0];
                        m_tlast <= (NB == 1);
                        state   <= PAYLOAD;
`endif
                    end
                end
`ifdef SAMPLE_STREAM_MUX_TIMESTAMP_EN
                TIMESTAMP: begin
                    if (m_tready) begin
                        if (!ts_hi) begin
                            m_tdata <= ts_q[15:8];
                            ts_hi   <= 1'b1;
                        end else begin
                            m_tdata <= sample_bytes[0];
                            m_tlast <= (NB == 1);
                            state   <= PAYLOAD;
                        end
                    end
                end
`endif
                PAYLOAD: begin
                    if (m_tready) begin
                        if (last_byte) begin
                            frames_sent <= frames_sent + 32'd1;
                            seq_q[ch_q] <= seq_q[ch_q] + SEQ_WIDTH'(1);
                            ptr <= (ch_q == PW'(NUM_CHANNELS - 1))
                                   ? '0 : ch_q + PW'(1);
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            byte_idx <= '0;
                            state    <= IDLE;
                        end else begin
                            m_tdata  <= sample_bytes[nxt_idx];
                            m_tlast  <= (nxt_idx == BW'(NB - 1));
                            byte_idx <= nxt_idx;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_stream_mux.sv
// Directed bench for sample_stream_mux with 4 channels of 32-bit samples.
// Timestamp checks are compiled in with SAMPLE_STREAM_MUX_TIMESTAMP_EN.
module tb_sample_stream_mux;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] s_tdata;
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tready;
    logic [7:0]   m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic [31:0]  frames_sent;

`ifdef SAMPLE_STREAM_MUX_TIMESTAMP_EN
    localparam int PO = 3;
`else
    localparam int PO = 1;
`endif
    localparam int FL = PO + 4;

    int errors = 0;
    int checks = 0;

    logic [7:0] fb [16];
    int         fn;
    int         lastpos;
    int         stall_bad;
    int         rdy_bad;

    logic [7:0] rr_exp [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10};

    always #5 clk = ~clk;

    sample_stream_mux #(
        .NUM_CHANNELS(4),
        .SAMPLE_WIDTH(32),
        .SEQ_WIDTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .frames_sent(frames_sent)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [31:0] d);
        s_tdata[k*32 +: 32] = d;
    endtask

    task automatic do_reset();
        s_tvalid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // receive one frame; bp toggles m_tready, keep leaves s_tvalid up
    task automatic collect(input bit bp, input bit keep,
                           input string tag);
        logic [7:0] pd;
        logic       pl;
        bit         stalled;
        bit         done;
        fn = 0;
        lastpos = -1;
        stall_bad = 0;
        rdy_bad = 0;
        stalled = 1'b0;
        done = 1'b0;
        pd = '0;
        pl = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            m_tready = bp ? ~m_tready : 1'b1;
            if (m_tvalid) begin
                if (|s_tready) rdy_bad++;
                if (!keep) s_tvalid = '0;
                if (stalled && (m_tdata !== pd || m_tlast !== pl))
                    stall_bad++;
                if (m_tready) begin
                    if (fn < 16) fb[fn] = m_tdata;
                    if (m_tlast) begin
                        lastpos = fn;
                        done = 1'b1;
                    end
                    fn++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd = m_tdata;
                    pl = m_tlast;
                end
            end
        end
        check({tag, "_len"}, fn, FL);
        check({tag, "_tlast_pos"}, lastpos, FL - 1);
        check({tag, "_busy_rdy"}, rdy_bad, 0);
        check({tag, "_stall"}, stall_bad, 0);
    endtask

    initial begin
        int  pos;
        bit  found;

        rst = 1'b1;
        s_tvalid = '0;
        s_tdata = '0;
        m_tready = 1'b0;
        repeat (3) @(negedge clk);

        s_tvalid = 4'hF;
        #1;
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_frames", frames_sent, 0);
        s_tvalid = '0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_tready", s_tready, 0);

        set_ch(2, 32'hA1B2C3D4);
        s_tvalid = 4'b0100;
        collect(1'b0, 1'b0, "single");
        check("single_hdr", fb[0], 8'h02);
        check("single_b0", fb[PO], 8'hD4);
        check("single_b1", fb[PO+1], 8'hC3);
        check("single_b2", fb[PO+2], 8'hB2);
        check("single_b3", fb[PO+3], 8'hA1);
        @(negedge clk);
        check("single_frames", frames_sent, 1);

        do_reset();
        for (int k = 0; k < 4; k++)
            set_ch(k, 32'h40302010 + k * 32'h01010101);
        s_tvalid = 4'hF;
        for (int f = 0; f < 5; f++) begin
            collect(1'b0, 1'b1, "rr");
            check("rr_hdr", fb[0], rr_exp[f]);
            check("rr_b0", fb[PO], 8'h10 + 8'(f % 4));
        end
        s_tvalid = '0;
        @(negedge clk);
        check("rr_frames", frames_sent, 5);

        set_ch(3, 32'h55667788);
        s_tvalid = 4'b1000;
        m_tready = 1'b0;
        collect(1'b1, 1'b0, "bp");
        check("bp_hdr", fb[0], 8'h13);
        check("bp_b0", fb[PO], 8'h88);
        check("bp_b1", fb[PO+1], 8'h77);
        check("bp_b2", fb[PO+2], 8'h66);
        check("bp_b3", fb[PO+3], 8'h55);
        m_tready = 1'b1;

        do_reset();
        set_ch(1, 32'hCAFE0001);
        for (int i = 1; i <= 17; i++) begin
            s_tvalid = 4'b0010;
            collect(1'b0, 1'b0, "wrap");
            if (i == 16) check("wrap_hdr16", fb[0], 8'hF1);
            if (i == 17) check("wrap_hdr17", fb[0], 8'h01);
        end
        @(negedge clk);
        check("wrap_frames", frames_sent, 17);

        set_ch(1, 32'hDDCCBBAA);
        s_tvalid = 4'b0010;
        m_tready = 1'b1;
        pos = 0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (m_tvalid) s_tvalid = '0;
            if (m_tvalid && pos == PO + 2) found = 1'b1;
            else if (m_tvalid && m_tready) pos++;
        end
        check("midrst_reach", found, 1);
        check("midrst_byte", m_tdata, 8'hCC);
        rst = 1'b1;
        #1;
        check("midrst_tvalid", m_tvalid, 0);
        check("midrst_tlast", m_tlast, 0);
        check("midrst_frames", frames_sent, 0);
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = 4'b0010;
        collect(1'b0, 1'b0, "postrst");
        check("postrst_hdr", fb[0], 8'h01);
        check("postrst_b0", fb[PO], 8'hAA);

`ifdef SAMPLE_STREAM_MUX_TIMESTAMP_EN
        s_tvalid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (16'h0123) @(posedge clk);
        @(negedge clk);
        set_ch(0, 32'h0A0B0C0D);
        s_tvalid = 4'b0001;
        collect(1'b0, 1'b0, "ts");
        check("ts_hdr", fb[0], 8'h00);
        check("ts_lo", fb[1], 8'h23);
        check("ts_hi", fb[2], 8'h01);
        check("ts_b0", fb[3], 8'h0D);
        check("ts_b3", fb[6], 8'h0A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
